// File: rtl/plru_pkg.sv
`default_nettype none
// ============================================================================
// Module   : plru_pkg
// Purpose  : Shared constants, state encoding and helpers for the 8-way
//            tree-PLRU victim selector.
// Revision : 1.0
// ============================================================================
package plru_pkg;

    localparam int NUMBER_WAY = 8;
    localparam int PLRU_BITS  = 7;

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Lowest set bit wins, so a malformed multi-hot vector still maps to one way.
    function automatic logic [2:0] f_onehot_to_idx(input logic [NUMBER_WAY-1:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUMBER_WAY - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/plru_tree_8.sv
`default_nettype none
// ============================================================================
// Module   : plru_tree_8
// Purpose  : Combinational 7-bit PLRU tree: victim walk and the two chained
//            per-cycle updates (access, then commit).
// Revision : 1.0
// ============================================================================
module plru_tree_8
    import plru_pkg::*;
(
    input  logic [PLRU_BITS-1:0]  i_acc_bits,
    input  logic [2:0]            i_acc_idx,
    input  logic [PLRU_BITS-1:0]  i_cmt_bits,
    input  logic [2:0]            i_cmt_idx,
    input  logic                  i_cmt_chain,
    input  logic [PLRU_BITS-1:0]  i_look_bits,
    output logic [PLRU_BITS-1:0]  o_acc_bits,
    output logic [PLRU_BITS-1:0]  o_cmt_bits,
    output logic [NUMBER_WAY-1:0] o_victim_way
);

    function automatic logic [PLRU_BITS-1:0] f_update(
        input logic [PLRU_BITS-1:0] bits,
        input logic [2:0]           idx
    );
        logic [PLRU_BITS-1:0] r;
        r    = bits;
        r[0] = ~idx[2];
        if (!idx[2]) begin
            r[1] = ~idx[1];
            if (!idx[1]) r[3] = ~idx[0];
            else         r[4] = ~idx[0];
        end else begin
            r[2] = ~idx[1];
            if (!idx[1]) r[5] = ~idx[0];
            else         r[6] = ~idx[0];
        end
        return r;
    endfunction

    logic [PLRU_BITS-1:0] w_acc_new;
    logic [PLRU_BITS-1:0] w_cmt_base;
    logic                 w_hi;
    logic                 w_mid;
    logic                 w_lo;

    assign w_acc_new  = f_update(i_acc_bits, i_acc_idx);
    // A commit to the set just touched by an access builds on the accessed bits.
    assign w_cmt_base = i_cmt_chain ? w_acc_new : i_cmt_bits;
    assign o_acc_bits = w_acc_new;
    assign o_cmt_bits = f_update(w_cmt_base, i_cmt_idx);

    always_comb begin
        w_hi  = i_look_bits[0];
        w_mid = w_hi ? i_look_bits[2] : i_look_bits[1];
        case ({w_hi, w_mid})
            2'b00:   w_lo = i_look_bits[3];
            2'b01:   w_lo = i_look_bits[4];
            2'b10:   w_lo = i_look_bits[5];
            default: w_lo = i_look_bits[6];
        endcase
    end

    assign o_victim_way = {{(NUMBER_WAY-1){1'b0}}, 1'b1} << {w_hi, w_mid, w_lo};

endmodule
`default_nettype wire

// File: rtl/plru_victim_select_8.sv
`default_nettype none
// ============================================================================
// Module   : plru_victim_select_8
// Purpose  : Per-set 8-way tree-PLRU with registered victim handshake and
//            update-on-commit. Optional macro PLRU_INVALID_FIRST_EN prefers
//            the lowest-index invalid way over the PLRU choice.
// Revision : 1.0
// ============================================================================
module plru_victim_select_8 #(
    parameter int NUMBER_WAY      = 8,
    parameter int NUMBER_SET      = 64,
    parameter int SET_INDEX_WIDTH = 6
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic                       access_valid_in,
    input  logic [SET_INDEX_WIDTH-1:0] access_set_in,
    input  logic [NUMBER_WAY-1:0]      access_way_in,
    input  logic                       victim_req_valid_in,
    input  logic [SET_INDEX_WIDTH-1:0] victim_req_set_in,
    input  logic [NUMBER_WAY-1:0]      valid_way_in,
    output logic                       victim_req_ready_out,
    output logic                       victim_valid_out,
    output logic [NUMBER_WAY-1:0]      victim_way_out,
    input  logic                       victim_ready_in
);
    import plru_pkg::*;

    logic [0:0]                 r_state;
    logic [0:0]                 w_state_nxt;
    logic [SET_INDEX_WIDTH-1:0] r_init_cnt;
    logic [PLRU_BITS-1:0]       r_tree [NUMBER_SET];

    logic                       r_vvalid;
    logic [NUMBER_WAY-1:0]      r_vway;
    logic [SET_INDEX_WIDTH-1:0] r_vset;

    logic                       w_run;
    logic                       w_req_fire;
    logic                       w_acc_en;
    logic                       w_cmt_en;
    logic                       w_chain;
    logic [2:0]                 w_acc_idx;
    logic [2:0]                 w_cmt_idx;
    logic [PLRU_BITS-1:0]       w_acc_new;
    logic [PLRU_BITS-1:0]       w_cmt_new;
    logic [PLRU_BITS-1:0]       w_look_bits;
    logic [NUMBER_WAY-1:0]      w_plru_way;
    logic [NUMBER_WAY-1:0]      w_victim_sel;

    assign w_run                = reset_in & (r_state == c_ST_RUN);
    assign victim_valid_out     = r_vvalid & reset_in;
    assign victim_way_out       = reset_in ? r_vway : '0;
    assign victim_req_ready_out = w_run & (~victim_valid_out | victim_ready_in);
    assign w_req_fire           = victim_req_valid_in & victim_req_ready_out;
    assign w_acc_en             = w_run & access_valid_in & (|access_way_in);
    assign w_cmt_en             = victim_valid_out & victim_ready_in;
    assign w_chain              = w_acc_en & w_cmt_en & (access_set_in == r_vset);
    assign w_acc_idx            = f_onehot_to_idx(access_way_in);
    assign w_cmt_idx            = f_onehot_to_idx(r_vway);

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_ST_INIT && r_init_cnt == SET_INDEX_WIDTH'(NUMBER_SET - 1)) begin
            w_state_nxt = c_ST_RUN;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_state    <= c_ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    // Commit bits already contain a same-set access, so commit has priority.
    always_comb begin
        w_look_bits = r_tree[victim_req_set_in];
        if (w_acc_en && access_set_in == victim_req_set_in) begin
            w_look_bits = w_acc_new;
        end
        if (w_cmt_en && r_vset == victim_req_set_in) begin
            w_look_bits = w_cmt_new;
        end
    end

    plru_tree_8 u_tree (
        .i_acc_bits   (r_tree[access_set_in]),
        .i_acc_idx    (w_acc_idx),
        .i_cmt_bits   (r_tree[r_vset]),
        .i_cmt_idx    (w_cmt_idx),
        .i_cmt_chain  (w_chain),
        .i_look_bits  (w_look_bits),
        .o_acc_bits   (w_acc_new),
        .o_cmt_bits   (w_cmt_new),
        .o_victim_way (w_plru_way)
    );

`ifdef PLRU_INVALID_FIRST_EN
    logic [NUMBER_WAY-1:0] w_invalid;
    assign w_invalid    = ~valid_way_in;
    assign w_victim_sel = (|w_invalid) ? (w_invalid & (~w_invalid + 1'b1)) : w_plru_way;
`else
    logic w_unused_valid;
    assign w_unused_valid = ^valid_way_in;
    assign w_victim_sel   = w_plru_way;
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            if (r_state == c_ST_INIT) begin
                r_tree[r_init_cnt] <= '0;
            end else begin
                if (w_acc_en && !w_chain) begin
                    r_tree[access_set_in] <= w_acc_new;
                end
                if (w_cmt_en) begin
                    r_tree[r_vset] <= w_cmt_new;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_vvalid <= 1'b0;
            r_vway   <= '0;
            r_vset   <= '0;
        end else if (w_req_fire) begin
            r_vvalid <= 1'b1;
            r_vway   <= w_victim_sel;
            r_vset   <= victim_req_set_in;
        end else if (w_cmt_en) begin
            r_vvalid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_plru_victim_select_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_plru_victim_select_8
// Purpose  : Directed self-checking bench for plru_victim_select_8.
// Revision : 1.0
// ============================================================================
module tb_plru_victim_select_8;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       access_valid_in;
    logic [5:0] access_set_in;
    logic [7:0] access_way_in;
    logic       victim_req_valid_in;
    logic [5:0] victim_req_set_in;
    logic [7:0] valid_way_in;
    logic       victim_req_ready_out;
    logic       victim_valid_out;
    logic [7:0] victim_way_out;
    logic       victim_ready_in;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    plru_victim_select_8 #(
        .NUMBER_WAY      (8),
        .NUMBER_SET      (64),
        .SET_INDEX_WIDTH (6)
    ) dut (
        .clk_in               (clk_in),
        .reset_in             (reset_in),
        .access_valid_in      (access_valid_in),
        .access_set_in        (access_set_in),
        .access_way_in        (access_way_in),
        .victim_req_valid_in  (victim_req_valid_in),
        .victim_req_set_in    (victim_req_set_in),
        .valid_way_in         (valid_way_in),
        .victim_req_ready_out (victim_req_ready_out),
        .victim_valid_out     (victim_valid_out),
        .victim_way_out       (victim_way_out),
        .victim_ready_in      (victim_ready_in)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic commit_victim();
        victim_ready_in = 1'b1;
        tick();
        victim_ready_in = 1'b0;
    endtask

    task automatic request(input logic [5:0] set);
        victim_req_valid_in = 1'b1;
        victim_req_set_in   = set;
        tick();
        victim_req_valid_in = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        int low_cnt;
        reset_in = 1'b0;
        repeat (3) tick();
        n_checks++; if (victim_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", victim_valid_out); end
        n_checks++; if (victim_way_out !== 8'h00) begin n_fail++; $display("FAIL reset_way: got %h expected 00", victim_way_out); end
        n_checks++; if (victim_req_ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", victim_req_ready_out); end
        reset_in = 1'b1;
        #1;
        low_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (victim_req_ready_out === 1'b0) low_cnt++;
            tick();
        end
        n_checks++; if (low_cnt != 64) begin n_fail++; $display("FAIL init_ready_low_cycles: got %0d expected 64", low_cnt); end
        n_checks++; if (victim_req_ready_out !== 1'b1) begin n_fail++; $display("FAIL ready_after_init: got %b expected 1", victim_req_ready_out); end
    endtask

    task automatic test_first_request();
        victim_req_valid_in = 1'b1;
        victim_req_set_in   = 6'd0;
        #1;
        n_checks++; if (victim_req_ready_out !== 1'b1) begin n_fail++; $display("FAIL first_req_ready: got %b expected 1", victim_req_ready_out); end
        tick();
        victim_req_valid_in = 1'b0;
        #1;
        n_checks++; if (victim_valid_out !== 1'b1 || victim_way_out !== 8'h01) begin n_fail++; $display("FAIL first_victim: got valid=%b way=%h expected valid=1 way=01", victim_valid_out, victim_way_out); end
        commit_victim();
        #1;
        n_checks++; if (victim_valid_out !== 1'b0) begin n_fail++; $display("FAIL first_commit_valid: got %b expected 0", victim_valid_out); end
    endtask

    task automatic test_access_update();
        access_valid_in = 1'b1;
        access_set_in   = 6'd3;
        access_way_in   = 8'h01;
        tick();
        access_valid_in = 1'b0;
        request(6'd3);
        n_checks++; if (victim_valid_out !== 1'b1 || victim_way_out !== 8'h10) begin n_fail++; $display("FAIL access_way0_set3: got valid=%b way=%h expected valid=1 way=10", victim_valid_out, victim_way_out); end
        commit_victim();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seq [8];
        exp_seq = '{8'h01, 8'h10, 8'h04, 8'h40, 8'h02, 8'h20, 8'h08, 8'h80};
        victim_req_valid_in = 1'b1;
        victim_req_set_in   = 6'd5;
        victim_ready_in     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) victim_req_valid_in = 1'b0;
            n_checks++; if (victim_valid_out !== 1'b1 || victim_way_out !== exp_seq[i]) begin n_fail++; $display("FAIL b2b_victim_%0d: got valid=%b way=%h expected valid=1 way=%h", i, victim_valid_out, victim_way_out, exp_seq[i]); end
        end
        tick();
        victim_ready_in = 1'b0;
        #1;
        n_checks++; if (victim_valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_valid: got %b expected 0", victim_valid_out); end
    endtask

    task automatic test_stall();
        int stable_cnt;
        victim_req_valid_in = 1'b1;
        victim_req_set_in   = 6'd7;
        tick();
        stable_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (victim_valid_out === 1'b1 && victim_way_out === 8'h01 && victim_req_ready_out === 1'b0) stable_cnt++;
            tick();
        end
        n_checks++; if (stable_cnt != 5) begin n_fail++; $display("FAIL stall_stable_cycles: got %0d expected 5", stable_cnt); end
        victim_req_valid_in = 1'b0;
        victim_ready_in     = 1'b1;
        #1;
        n_checks++; if (victim_req_ready_out !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b expected 1", victim_req_ready_out); end
        tick();
        victim_ready_in = 1'b0;
        request(6'd7);
        n_checks++; if (victim_way_out !== 8'h10) begin n_fail++; $display("FAIL stall_single_update: got %h expected 10", victim_way_out); end
        commit_victim();
    endtask

    task automatic test_forwarding();
        victim_req_valid_in = 1'b1;
        victim_req_set_in   = 6'd2;
        tick();
        n_checks++; if (victim_way_out !== 8'h01) begin n_fail++; $display("FAIL fwd_first_victim: got %h expected 01", victim_way_out); end
        victim_ready_in = 1'b1;
        #1;
        n_checks++; if (victim_req_ready_out !== 1'b1) begin n_fail++; $display("FAIL fwd_ready: got %b expected 1", victim_req_ready_out); end
        tick();
        victim_req_valid_in = 1'b0;
        victim_ready_in     = 1'b0;
        #1;
        n_checks++; if (victim_valid_out !== 1'b1 || victim_way_out !== 8'h10) begin n_fail++; $display("FAIL fwd_commit_victim: got valid=%b way=%h expected valid=1 way=10", victim_valid_out, victim_way_out); end
        commit_victim();
    endtask

    task automatic test_same_set_order();
        victim_req_valid_in = 1'b1;
        victim_req_set_in   = 6'd9;
        tick();
        n_checks++; if (victim_way_out !== 8'h01) begin n_fail++; $display("FAIL order_first_victim: got %h expected 01", victim_way_out); end
        victim_ready_in = 1'b1;
        access_valid_in = 1'b1;
        access_set_in   = 6'd9;
        access_way_in   = 8'h10;
        tick();
        access_valid_in     = 1'b0;
        victim_req_valid_in = 1'b0;
        victim_ready_in     = 1'b0;
        #1;
        n_checks++; if (victim_way_out !== 8'h40) begin n_fail++; $display("FAIL order_access_then_commit: got %h expected 40", victim_way_out); end
        commit_victim();
        request(6'd9);
        n_checks++; if (victim_way_out !== 8'h04) begin n_fail++; $display("FAIL order_stored_bits: got %h expected 04", victim_way_out); end
        commit_victim();
    endtask

    task automatic test_different_sets();
        request(6'd11);
        victim_ready_in = 1'b1;
        access_valid_in = 1'b1;
        access_set_in   = 6'd10;
        access_way_in   = 8'h01;
        tick();
        access_valid_in = 1'b0;
        victim_ready_in = 1'b0;
        request(6'd10);
        n_checks++; if (victim_way_out !== 8'h10) begin n_fail++; $display("FAIL diff_sets_access: got %h expected 10", victim_way_out); end
        commit_victim();
        request(6'd11);
        n_checks++; if (victim_way_out !== 8'h10) begin n_fail++; $display("FAIL diff_sets_commit: got %h expected 10", victim_way_out); end
        commit_victim();
    endtask

    task automatic test_invalid_first();
        logic [7:0] exp_way;
`ifdef PLRU_INVALID_FIRST_EN
        exp_way = 8'h04;
`else
        exp_way = 8'h01;
`endif
        valid_way_in = 8'hFB;
        request(6'd12);
        valid_way_in = 8'hFF;
        n_checks++; if (victim_way_out !== exp_way) begin n_fail++; $display("FAIL invalid_first: got %h expected %h", victim_way_out, exp_way); end
        commit_victim();
        request(6'd12);
        n_checks++; if (victim_way_out !== 8'h10) begin n_fail++; $display("FAIL all_valid_plru: got %h expected 10", victim_way_out); end
        commit_victim();
    endtask

    task automatic test_reset_mid();
        int low_cnt;
        request(6'd13);
        n_checks++; if (victim_valid_out !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: got %b expected 1", victim_valid_out); end
        reset_in        = 1'b0;
        victim_ready_in = 1'b1;
        tick();
        n_checks++; if (victim_valid_out !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_drop: got %b expected 0", victim_valid_out); end
        n_checks++; if (victim_req_ready_out !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: got %b expected 0", victim_req_ready_out); end
        victim_ready_in = 1'b0;
        reset_in        = 1'b1;
        #1;
        low_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (victim_req_ready_out === 1'b0) low_cnt++;
            tick();
        end
        n_checks++; if (low_cnt != 64) begin n_fail++; $display("FAIL rmid_init_cycles: got %0d expected 64", low_cnt); end
        n_checks++; if (victim_req_ready_out !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_after_init: got %b expected 1", victim_req_ready_out); end
        request(6'd13);
        n_checks++; if (victim_way_out !== 8'h01) begin n_fail++; $display("FAIL rmid_no_commit: got %h expected 01", victim_way_out); end
        commit_victim();
        request(6'd5);
        n_checks++; if (victim_way_out !== 8'h01) begin n_fail++; $display("FAIL rmid_set5_cleared: got %h expected 01", victim_way_out); end
        commit_victim();
    endtask

    initial begin
        reset_in            = 1'b0;
        access_valid_in     = 1'b0;
        access_set_in       = '0;
        access_way_in       = '0;
        victim_req_valid_in = 1'b0;
        victim_req_set_in   = '0;
        valid_way_in        = 8'hFF;
        victim_ready_in     = 1'b0;

        test_reset();
        test_first_request();
        test_access_update();
        test_back_to_back();
        test_stall();
        test_forwarding();
        test_same_set_order();
        test_different_sets();
        test_invalid_first();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plru_victim_select_8.md
PLRU_VICTIM_SELECT_8 -- requirements
Module: plru_victim_select_8

Interface
REQ-001 SHALL have parameter NUMBER_WAY, default 8, fixed number of ways (tree width is fixed at 8).
REQ-002 SHALL have parameter NUMBER_SET, default 64, number of sets tracked.
REQ-003 SHALL have parameter SET_INDEX_WIDTH, default 6, equal to log2(NUMBER_SET).
REQ-004 SHALL have clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have reset_in  input  1  reset, synchronous and active-low.
REQ-006 SHALL have access_valid_in  input  1  hit-update strobe.
REQ-007 SHALL have access_set_in  input  SET_INDEX_WIDTH  hit set index.
REQ-008 SHALL have access_way_in  input  NUMBER_WAY  one-hot hit way.
REQ-009 SHALL have victim_req_valid_in  input  1  victim request valid.
REQ-010 SHALL have victim_req_set_in  input  SET_INDEX_WIDTH  requested set.
REQ-011 SHALL have valid_way_in  input  NUMBER_WAY  per-way valid bits of the requested set.
REQ-012 SHALL have victim_req_ready_out  output  1  request accepted when valid and ready are both high.
REQ-013 SHALL have victim_valid_out  output  1  victim result valid.
REQ-014 SHALL have victim_way_out  output  NUMBER_WAY  one-hot victim, drives the sel_in of the downstream way mux.
REQ-015 SHALL have victim_ready_in  input  1  consumer accepts the victim (commit).

Function
REQ-016 SHALL keep 7 tree bits per set: node 0 is the root; nodes 1 and 2 cover ways 0-3 and 4-7; nodes 3-6 cover the way pairs 0-1, 2-3, 4-5 and 6-7.
REQ-017 SHALL treat a node bit of 0 as "victim in left/lower half"; the victim is found by walking from the root.
REQ-018 SHALL, on an update for way w, set every node on w's path to point away from w.
REQ-019 SHALL implement the FSM states INIT and RUN; INIT sweeps a set counter from 0 to NUMBER_SET-1, zeroing one set per cycle, and then enters RUN.
REQ-020 SHALL drive victim_req_ready_out = RUN and (not victim_valid_out or victim_ready_in).
REQ-021 SHALL, for a request accepted in cycle N, assert victim_valid_out in cycle N+1 with the victim registered (latency 1).
REQ-022 SHALL hold victim_way_out and victim_valid_out stable while victim_valid_out is high and victim_ready_in is low.
REQ-023 SHALL treat a victim handshake (victim_valid_out and victim_ready_in) as a commit that applies the REQ-018 update for that victim way in its set.
REQ-024 SHALL, when an access update and a commit target the same set in one cycle, apply the access update first and the commit last.
REQ-025 SHALL, when an access update and a commit target different sets, apply both.
REQ-026 SHALL forward any same-cycle access or commit updates into a lookup of the same set, so the lookup never sees stale bits.
REQ-027 SHALL ignore access_valid_in during INIT.
REQ-028 SHALL produce a victim_way_out that is always exactly one-hot whenever victim_valid_out is high.

Reset
REQ-029 SHALL, while reset_in is low, force victim_valid_out=0, victim_way_out=0 and victim_req_ready_out=0, and enter INIT with the counter at 0.
REQ-030 SHALL, on reset asserted mid-operation, drop any pending victim without a commit and restart INIT.

Configuration
REQ-031 SHALL, with PLRU_INVALID_FIRST_EN defined, choose the lowest-index way whose valid_way_in bit is 0; PLRU order is used only when all bits are 1.
REQ-032 SHALL, without PLRU_INVALID_FIRST_EN, keep the valid_way_in port present but ignore it (pure PLRU).

Structure
REQ-033 SHALL place NUMBER_WAY, PLRU_BITS=7 and the INIT/RUN state encoding in shared package plru_pkg.
REQ-034 SHALL use one combinational sub-module, plru_tree_8, providing victim-from-bits and bits-after-update.

Verification
REQ-035 SHALL cover: reset release -> ready low for 64 cycles; then a request to set 0 -> victim 8'b0000_0001 one cycle later.
REQ-036 SHALL cover: access way 0 in set 3, then a request to set 3 -> victim 8'b0001_0000.
REQ-037 SHALL cover: 8 back-to-back committed requests to set 5 with no accesses -> victims in way order 0,4,2,6,1,5,3,7.
REQ-038 SHALL cover: victim_ready_in low for 5 cycles -> output stable and victim_req_ready_out low; no tree update until the commit.
REQ-039 SHALL cover: same-cycle commit of way 0 in set 2 and a new request to set 2 -> the new victim is way 4 (forwarding).
REQ-040 SHALL cover: with the macro, valid_way_in=8'b1111_1011 -> victim 8'b0000_0100; without the macro -> 8'b0000_0001; and reset while victim_valid_out is high -> valid low next cycle and INIT restarts.
